// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// valid/ready requesters; result and Zero flag are returned on per-requester responses.
module alu_share_arb #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_c,
    output logic        rsp0_zero,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_c,
    output logic        rsp1_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic        zero_q, zero_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant0, grant1, owner_rsp_ready;

    always_comb begin
        // On a tie the requester that was not served last wins.
        grant1 = req1_valid && (!req0_valid || !last_q);
        grant0 = req0_valid && !grant1;
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        zero_d  = zero_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = grant1 ? req1_op : req0_op;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    owner_d = grant1;
                    cnt_d   = CNT_INIT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    c_d     = alu_c;
                    zero_d  = alu_zero;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && grant0 && !rst;
        req1_ready = (state_q == IDLE) && grant1 && !rst;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        rsp0_c     = c_q;
        rsp1_c     = c_q;
        rsp0_zero  = zero_q;
        rsp1_zero  = zero_q;
        alu_a      = a_q;
        alu_b      = b_q;
        alu_op     = op_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            zero_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: one instance with EXEC_CYCLES=1, one with 4,
// each driven by a small behavioural ALU (add/sub/sra).
module tb_alu_share_arb;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b10001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance with EXEC_CYCLES=1
    logic        r0_valid = 0, r0_ready, s0_valid, s0_ready = 0, s0_zero;
    logic [4:0]  r0_op = '0;
    logic [31:0] r0_a = '0, r0_b = '0, s0_c;
    logic        r1_valid = 0, r1_ready, s1_valid, s1_ready = 0, s1_zero;
    logic [4:0]  r1_op = '0;
    logic [31:0] r1_a = '0, r1_b = '0, s1_c;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_op;
    logic        alu_zero;

    // Instance with EXEC_CYCLES=4 (requester 1 tied idle)
    logic        m0_valid = 0, m0_ready, n0_valid, n0_ready = 0, n0_zero;
    logic [4:0]  m0_op = '0;
    logic [31:0] m0_a = '0, m0_b = '0, n0_c;
    logic        m1_valid = 0, m1_ready, n1_valid, n1_ready = 0, n1_zero;
    logic [4:0]  m1_op = '0;
    logic [31:0] m1_a = '0, m1_b = '0, n1_c;
    logic [31:0] malu_a, malu_b, malu_c;
    logic [4:0]  malu_op;
    logic        malu_zero;

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_SUB:  alu_c = alu_a - alu_b;
            OP_SRA:  alu_c = $signed(alu_a) >>> alu_b[4:0];
            default: alu_c = '0;
        endcase
        alu_zero = (alu_c == 32'd0);
        case (malu_op)
            OP_ADD:  malu_c = malu_a + malu_b;
            OP_SUB:  malu_c = malu_a - malu_b;
            OP_SRA:  malu_c = $signed(malu_a) >>> malu_b[4:0];
            default: malu_c = '0;
        endcase
        malu_zero = (malu_c == 32'd0);
    end

    alu_share_arb #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
        .rsp0_valid(s0_valid), .rsp0_ready(s0_ready), .rsp0_c(s0_c), .rsp0_zero(s0_zero),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
        .rsp1_valid(s1_valid), .rsp1_ready(s1_ready), .rsp1_c(s1_c), .rsp1_zero(s1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero)
    );

    alu_share_arb #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(m0_valid), .req0_ready(m0_ready), .req0_op(m0_op), .req0_a(m0_a), .req0_b(m0_b),
        .rsp0_valid(n0_valid), .rsp0_ready(n0_ready), .rsp0_c(n0_c), .rsp0_zero(n0_zero),
        .req1_valid(m1_valid), .req1_ready(m1_ready), .req1_op(m1_op), .req1_a(m1_a), .req1_b(m1_b),
        .rsp1_valid(n1_valid), .rsp1_ready(n1_ready), .rsp1_c(n1_c), .rsp1_zero(n1_zero),
        .alu_a(malu_a), .alu_b(malu_b), .alu_op(malu_op), .alu_c(malu_c), .alu_zero(malu_zero)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        #1;
        checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b%b exp 00", r0_ready, r1_ready); end
        checks++; if (s0_valid !== 1'b0 || s1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b%b exp 00", s0_valid, s1_valid); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0) begin errors++; $display("FAIL reset_alu_ops got %h %h %h exp 0 0 0", alu_a, alu_b, alu_op); end
        checks++; if (s0_c !== 32'd0 || s0_zero !== 1'b0) begin errors++; $display("FAIL reset_result got %h %b exp 0 0", s0_c, s0_zero); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        step();
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'd5; r0_b = 32'd7;
        #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL add_accept got %b%b exp 10", r0_ready, r1_ready); end
        step();
        r0_valid = 0;
        #1;
        checks++; if (r0_ready !== 1'b0 || s0_valid !== 1'b0) begin errors++; $display("FAIL add_exec got ready %b rsp %b exp 0 0", r0_ready, s0_valid); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== OP_ADD) begin errors++; $display("FAIL add_alu_in got %h %h %h exp 5 7 %h", alu_a, alu_b, alu_op, OP_ADD); end
        step();
        s0_ready = 1;
        #1;
        checks++; if (s0_valid !== 1'b1 || s1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_valid got %b%b exp 10", s0_valid, s1_valid); end
        checks++; if (s0_c !== 32'd12 || s0_zero !== 1'b0) begin errors++; $display("FAIL add_rsp_data got %h %b exp c 0", s0_c, s0_zero); end
        step();
        s0_ready = 0;
        #1;
        checks++; if (s0_valid !== 1'b0 || s1_valid !== 1'b0) begin errors++; $display("FAIL add_done got %b%b exp 00", s0_valid, s1_valid); end
    endtask

    task automatic test_zero_stall();
        step();
        r1_valid = 1; r1_op = OP_SUB; r1_a = 32'd3; r1_b = 32'd3;
        #1;
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL sub_accept got %b exp 1", r1_ready); end
        step();
        r1_valid = 0;
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'd1; r0_b = 32'd2;
        #1;
        checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL wait_in_exec got %b exp 0", r0_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) s1_ready = 1;
            #1;
            checks++; if (s1_valid !== 1'b1 || s0_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b%b exp 10", i, s1_valid, s0_valid); end
            checks++; if (s1_c !== 32'd0 || s1_zero !== 1'b1) begin errors++; $display("FAIL stall_data[%0d] got %h %b exp 0 1", i, s1_c, s1_zero); end
            checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL stall_req0_ready[%0d] got %b exp 0", i, r0_ready); end
        end
        step();
        s1_ready = 0;
        #1;
        checks++; if (r0_ready !== 1'b1 || s1_valid !== 1'b0) begin errors++; $display("FAIL after_rsp got ready %b rsp1 %b exp 1 0", r0_ready, s1_valid); end
        step();
        r0_valid = 0;
        step();
        s0_ready = 1;
        #1;
        checks++; if (s0_valid !== 1'b1 || s0_c !== 32'd3) begin errors++; $display("FAIL queued_add got %b %h exp 1 3", s0_valid, s0_c); end
        step();
        s0_ready = 0;
    endtask

    task automatic test_arbitration();
        rst = 1; step(); rst = 0;
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'd10; r0_b = 32'd1;
        r1_valid = 1; r1_op = OP_ADD; r1_a = 32'd20; r1_b = 32'd2;
        s0_ready = 1; s1_ready = 1;
        for (int i = 0; i < 12; i++) begin
            int owner;
            owner = (i / 3) % 2;
            #1;
            if (i % 3 == 0) begin
                checks++; if (r0_ready !== (owner == 0) || r1_ready !== (owner == 1)) begin errors++; $display("FAIL arb_grant[%0d] got %b%b exp owner %0d", i, r0_ready, r1_ready, owner); end
            end else begin
                checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL arb_idle_ready[%0d] got %b%b exp 00", i, r0_ready, r1_ready); end
            end
            if (i % 3 == 2) begin
                checks++; if (s0_valid !== (owner == 0) || s1_valid !== (owner == 1)) begin errors++; $display("FAIL arb_rsp[%0d] got %b%b exp owner %0d", i, s0_valid, s1_valid, owner); end
                checks++; if (s0_c !== (owner == 0 ? 32'd11 : 32'd22)) begin errors++; $display("FAIL arb_c[%0d] got %0d exp %0d", i, s0_c, owner == 0 ? 11 : 22); end
            end
            step();
        end
        r0_valid = 0; r1_valid = 0; s0_ready = 0; s1_ready = 0;
        step();
    endtask

    task automatic test_multi_cycle();
        step();
        m0_valid = 1; m0_op = OP_SRA; m0_a = 32'h8000_0000; m0_b = 32'd4;
        #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL mc_accept got %b exp 1", m0_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            m0_valid = 0;
            #1;
            checks++; if (malu_a !== 32'h8000_0000 || malu_b !== 32'd4 || malu_op !== OP_SRA) begin errors++; $display("FAIL mc_hold[%0d] got %h %h %h exp 80000000 4 %h", i, malu_a, malu_b, malu_op, OP_SRA); end
            checks++; if (n0_valid !== 1'b0) begin errors++; $display("FAIL mc_early_rsp[%0d] got %b exp 0", i, n0_valid); end
        end
        step();
        n0_ready = 1;
        #1;
        checks++; if (n0_valid !== 1'b1 || n1_valid !== 1'b0) begin errors++; $display("FAIL mc_rsp_valid got %b%b exp 10", n0_valid, n1_valid); end
        checks++; if (n0_c !== 32'hF800_0000 || n0_zero !== 1'b0) begin errors++; $display("FAIL mc_rsp_data got %h %b exp f8000000 0", n0_c, n0_zero); end
        step();
        n0_ready = 0;
        #1;
        checks++; if (n0_valid !== 1'b0) begin errors++; $display("FAIL mc_done got %b exp 0", n0_valid); end
    endtask

    task automatic test_reset_mid();
        // Serve requester 0 first so that last_q is 0 before the resets.
        step();
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'd1; r0_b = 32'd1;
        step(); r0_valid = 0;
        step(); s0_ready = 1;
        step(); s0_ready = 0;
        r0_valid = 1; r0_a = 32'd4;
        #1;
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL rm_accept got %b exp 1", r0_ready); end
        step();
        r0_valid = 0; rst = 1;
        step();
        rst = 0;
        #1;
        checks++; if (s0_valid !== 1'b0 || s1_valid !== 1'b0 || alu_a !== 32'd0) begin errors++; $display("FAIL rm_exec_reset got %b%b a=%h exp 00 a=0", s0_valid, s1_valid, alu_a); end
        step();
        #1;
        checks++; if (s0_valid !== 1'b0 || s1_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale got %b%b exp 00", s0_valid, s1_valid); end
        r1_valid = 1; r1_op = OP_ADD; r1_a = 32'd9; r1_b = 32'd9;
        step(); r1_valid = 0;
        step();
        #1;
        checks++; if (s1_valid !== 1'b1 || s1_c !== 32'd18) begin errors++; $display("FAIL rm_resp_before got %b %h exp 1 12", s1_valid, s1_c); end
        rst = 1;
        step();
        rst = 0;
        #1;
        checks++; if (s1_valid !== 1'b0 || s1_c !== 32'd0) begin errors++; $display("FAIL rm_resp_reset got %b %h exp 0 0", s1_valid, s1_c); end
        step();
        r0_valid = 1; r0_op = OP_ADD; r0_a = 32'd2; r0_b = 32'd2;
        r1_valid = 1;
        #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL rm_tie got %b%b exp 10", r0_ready, r1_ready); end
        step(); r0_valid = 0; r1_valid = 0;
        step(); s0_ready = 1;
        step(); s0_ready = 0;
    endtask

    task automatic test_dropped();
        step();
        r0_valid = 1; r0_op = OP_SUB; r0_a = 32'd8; r0_b = 32'd5;
        step();
        r0_valid = 0; r1_valid = 1; r1_op = OP_ADD; r1_a = 32'd1; r1_b = 32'd1;
        #1;
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_exec got %b exp 0", r1_ready); end
        step();
        r1_valid = 0; s0_ready = 1;
        #1;
        checks++; if (s0_valid !== 1'b1 || s0_c !== 32'd3) begin errors++; $display("FAIL drop_rsp0 got %b %h exp 1 3", s0_valid, s0_c); end
        step();
        s0_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (r1_ready !== 1'b0 || s1_valid !== 1'b0 || s0_valid !== 1'b0) begin errors++; $display("FAIL drop_never[%0d] got %b%b%b exp 000", i, r1_ready, s1_valid, s0_valid); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_zero_stall();
        test_arbitration();
        test_multi_cycle();
        test_reset_mid();
        test_dropped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
